// File: rtl/compensation_merge_unit_if.sv
// Stream interface for compensation_merge_unit.
//   Input side : psum_valid/in_ready handshake carrying psum_in and comp_in.
//   Output side: out_valid/out_ready handshake carrying out_data and out_index.
// The master modport is the producer/consumer side; the slave modport is the unit.
interface compensation_merge_unit_if #(
  parameter int unsigned PSUM_WIDTH = 20,
  parameter int unsigned COMP_WIDTH = 13,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned ROWS       = 8
);
  localparam int unsigned IdxW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                         psum_valid;
  logic                         in_ready;
  logic signed [PSUM_WIDTH-1:0] psum_in;
  logic signed [COMP_WIDTH-1:0] comp_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic [IdxW-1:0]              out_index;

  modport master (
    output psum_valid, psum_in, comp_in, out_ready,
    input  in_ready, out_valid, out_data, out_index
  );

  modport slave (
    input  psum_valid, psum_in, comp_in, out_ready,
    output in_ready, out_valid, out_data, out_index
  );
endinterface

// File: rtl/compensation_merge_unit.sv
// Merges main partial sums with their compensation sums, requantizes (round half up,
// optional ReLU, saturation) and buffers results in a small output FIFO.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : begins a tile when idle; relu_en is latched with it
//   bus        : input pair stream (psum_valid/in_ready) and result stream (out_valid/out_ready)
//   busy       : tile in progress
//   tile_done  : pulses when the last result of a tile is written to the FIFO
//   sat_flag   : sticky saturation indicator, cleared by start
module compensation_merge_unit #(
  parameter int unsigned PSUM_WIDTH  = 20,
  parameter int unsigned COMP_WIDTH  = 13,
  parameter int unsigned COMP_SHIFT  = 0,
  parameter int unsigned QUANT_SHIFT = 2,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned ROWS        = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          relu_en,
  compensation_merge_unit_if.slave      bus,
  output logic                          busy,
  output logic                          tile_done,
  output logic                          sat_flag
);
  localparam int unsigned IdxW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam int unsigned SumW = ((PSUM_WIDTH > COMP_WIDTH + COMP_SHIFT) ?
                                  PSUM_WIDTH : COMP_WIDTH + COMP_SHIFT) + 1;
  // One extra bit so the rounding offset can never wrap the sum.
  localparam int unsigned RndW = SumW + 1;
  localparam int unsigned EntW = OUT_WIDTH + IdxW;

  localparam logic signed [RndW-1:0] Half   = RndW'(1) << (QUANT_SHIFT - 1);
  localparam logic signed [RndW-1:0] OutMax = RndW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RndW-1:0] OutMin = RndW'(-(1 << (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {StIdle, StMerge, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   relu_q, relu_d;
  logic                   sat_q, sat_d;

  logic                   s1_valid_q, s1_valid_d;
  logic signed [SumW-1:0] s1_sum_q, s1_sum_d;
  logic [IdxW-1:0]        s1_idx_q, s1_idx_d;
  logic                   s1_last_q, s1_last_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [OUT_WIDTH-1:0]   s2_data_q, s2_data_d;
  logic [IdxW-1:0]        s2_idx_q, s2_idx_d;
  logic                   s2_last_q, s2_last_d;

  logic [EntW-1:0]        mem_q [FIFO_DEPTH];
  logic [EntW-1:0]        mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [EntW-1:0]        head_q, head_d;

  logic                   in_ready, accept, sat_now, push, pop;
  logic [OccW-1:0]        occ;
  logic signed [SumW-1:0] psum_ext, comp_ext;
  logic signed [RndW-1:0] rnd, quant;

  // Control, stage 1 (add) and stage 2 (requantize).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    relu_d  = relu_q;
    sat_d   = sat_q;

    // Slots already promised to in-flight pairs count as occupied, so the FIFO never overflows.
    occ      = {1'b0, count_q} + OccW'(s1_valid_q) + OccW'(s2_valid_q);
    in_ready = (state_q == StMerge) && (occ < OccW'(FIFO_DEPTH));
    accept   = in_ready && bus.psum_valid;

    psum_ext   = {{(SumW - PSUM_WIDTH){bus.psum_in[PSUM_WIDTH-1]}}, bus.psum_in};
    comp_ext   = {{(SumW - COMP_WIDTH){bus.comp_in[COMP_WIDTH-1]}}, bus.comp_in};
    s1_valid_d = accept;
    s1_sum_d   = psum_ext + (comp_ext <<< COMP_SHIFT);
    s1_idx_d   = idx_q;
    s1_last_d  = (idx_q == IdxW'(ROWS - 1));

    rnd     = {s1_sum_q[SumW-1], s1_sum_q} + Half;
    quant   = rnd >>> QUANT_SHIFT;
    sat_now = 1'b0;
    if (relu_q && quant[RndW-1]) begin
      quant = '0;
    end
    if (quant > OutMax) begin
      quant   = OutMax;
      sat_now = 1'b1;
    end else if (quant < OutMin) begin
      quant   = OutMin;
      sat_now = 1'b1;
    end
    s2_valid_d = s1_valid_q;
    s2_data_d  = quant[OUT_WIDTH-1:0];
    s2_idx_d   = s1_idx_q;
    s2_last_d  = s1_last_q;
    if (s1_valid_q && sat_now) begin
      sat_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMerge;
          idx_d   = '0;
          sat_d   = 1'b0;
          relu_d  = relu_en;
        end
      end
      StMerge: begin
        if (accept) begin
          idx_d = idx_q + IdxW'(1);
          if (s1_last_d) begin
            state_d = StDrain;
            idx_d   = '0;
          end
        end
      end
      StDrain: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output FIFO with a registered head that is refreshed from the post-update storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    push     = s2_valid_q;
    pop      = (count_q != '0) && bus.out_ready;
    if (push) begin
      mem_d[wr_ptr_q] = {s2_idx_q, s2_data_q};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // When the FIFO empties the head keeps its last value.
    if (count_d != '0) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      relu_q     <= 1'b0;
      sat_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_idx_q   <= '0;
      s2_last_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      relu_q     <= relu_d;
      sat_q      <= sat_d;
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_idx_q   <= s1_idx_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_idx_q   <= s2_idx_d;
      s2_last_q  <= s2_last_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = head_q[OUT_WIDTH-1:0];
  assign bus.out_index = head_q[EntW-1:OUT_WIDTH];
  assign busy          = (state_q != StIdle);
  assign tile_done     = s2_valid_q && s2_last_q;
  assign sat_flag      = sat_q;
endmodule

// File: doc/compensation_merge_unit.md
Name: compensation_merge_unit

Overview:
Sits directly downstream of the compensation accumulator and the main partial-sum accumulator. For each output tile it takes a serial stream of ROWS main partial sums, each paired with its compensation sum. It adds the two and requantizes with rounding, ReLU and saturation. Results are buffered in a small output FIFO that the activation write-back path drains over a valid/ready handshake.

Parameters:
PSUM_WIDTH, 20, signed width of main partial sum
COMP_WIDTH, 13, signed width of compensation sum (matches compensation accumulator output, 8+4+1)
COMP_SHIFT, 0, left shift applied to compensation sum before the add
QUANT_SHIFT, 2, arithmetic right shift for requantization (must be >=1)
OUT_WIDTH, 8, signed output activation width
ROWS, 8, results per tile
FIFO_DEPTH, 4, output FIFO entries (power of two)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a tile; ignored unless FSM is IDLE
relu_en  in  1  1 = clamp negatives to 0; sampled on start
psum_valid  in  1  psum_in/comp_in valid
in_ready  out  1  unit can accept a pair this cycle
psum_in  in  PSUM_WIDTH  signed main partial sum
comp_in  in  COMP_WIDTH  signed compensation sum, same cycle as psum_in
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  OUT_WIDTH  signed requantized result
out_index  out  clog2(ROWS)  result position within tile
busy  out  1  FSM not IDLE
tile_done  out  1  one-cycle pulse when last result of tile enters FIFO
sat_flag  out  1  sticky; set on any saturation; cleared by start or rst

Behaviour:
- Reset (async, rst=1): FSM=IDLE, counters=0, FIFO empty, pipeline valids=0. All outputs 0, including out_data and out_index. rst mid-tile discards all in-flight and buffered data.
- FSM IDLE: in_ready=0, psum_valid ignored. On start, go to MERGE, set idx=0, clear sat_flag, latch relu_en.
- FSM MERGE: a pair is accepted when psum_valid && in_ready. Each accept increments idx. The accept with idx==ROWS-1 moves the FSM to DRAIN.
- FSM DRAIN: in_ready=0. When the pipeline is empty, go to IDLE.
- tile_done pulses in the cycle the idx==ROWS-1 result is written to the FIFO.
- Back-pressure: in_ready = MERGE && (fifo_count + inflight) < FIFO_DEPTH. inflight is the number of valid pipeline stages (0..2), so a FIFO overflow cannot occur. A FIFO write and read in the same cycle leaves the count unchanged.
- Pipeline stage 1 (registered add): sum = sext(psum_in) + (sext(comp_in) << COMP_SHIFT). Width is max(PSUM_WIDTH, COMP_WIDTH+COMP_SHIFT)+1, so the add never wraps.
- Pipeline stage 2 (registered): r = (sum + 2^(QUANT_SHIFT-1)) >>> QUANT_SHIFT, i.e. round half up with an arithmetic shift.
- Stage 2 then applies ReLU if relu_en (r<0 -> 0), then saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Any clamp by saturation sets sat_flag; a ReLU clamp does not.
- Stage 2 writes the FIFO along with its index.
- Latency: a pair accepted at cycle N is written to the FIFO at the end of N+2. out_valid is high at N+3 if the FIFO was empty.
- FIFO: registered head. out_data/out_index are stable while out_valid && !out_ready. With the FIFO empty, out_valid=0 and out_data holds its last value.
- start while busy: ignored, no state change.
- psum_valid while in_ready=0: not accepted, no side effects.

Test Plan:
- Basic tile (defaults, relu_en=0): pairs (100,5),(4,0),(-8,1)… ×8 with out_ready=1 -> out_data 26,1,-2 (floor((-7+2)/4)=-2), out_index 0..7. First out_valid 3 cycles after first accept; tile_done pulses once; busy falls after the last FIFO write.
- ReLU and negative rounding: psum=-50, comp=3, relu_en=1 -> 0. Same pair with relu_en=0 -> -12. sat_flag stays 0 in both cases.
- Saturation: psum=1000, comp=0 -> 127 and sat_flag=1. Then psum=-2000 with relu_en=0 -> -128. A following start clears sat_flag.
- COMP_SHIFT=2 build: psum=0, comp=-4 -> sum -16 -> -4.
- Back-pressure: hold out_ready=0 while feeding 8 pairs. in_ready drops after exactly 4 accepts and the FIFO holds 4 entries with the head stable. Release out_ready: all 8 results arrive in order, with none lost or duplicated.
- Reset mid-tile: assert rst after 3 accepts with the FIFO non-empty -> out_valid=0, busy=0, FIFO empty. A new start then produces a full clean tile with out_index starting at 0.
